i2c_entity: RTL and testbench

I2C_ENTITY -- requirements
Module: i2c_entity

---
 rtl/i2c_entity.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_entity.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_entity.sv
// I2C master for 16-bit-register read/write transactions. The bus is paced by a quarter-period down-counter.
// Optional clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_entity #(
    parameter int unsigned QUARTER_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_read,
    input  logic [6:0]  slave_adress,
    input  logic [15:0] register_address,
    input  logic [9:0]  nb_of_bytes,
    input  logic [7:0]  data_in,
    input  logic        SCL_in,
    input  logic        SDA_in,
    output logic [15:0] data_out,
    output logic        ready,
    output logic        error_out,
    output logic        SCL_out,
    output logic        SDA_out,
    output logic        SCL_t,
    output logic        SDA_t
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, REG_HI, REG_LO, REG_ACK, WR_DATA, WR_ACK,
        RESTART, ADDR_RD, ADDR_RD_ACK, RD_DATA, M_ACK, STOP
    } state_t;

    localparam logic [9:0] Q_LOAD = 10'(QUARTER_DIV - 1);

    state_t      state;
    logic [1:0]  qtr;
    logic [1:0]  last_q;
    logic [9:0]  q_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic [9:0]  byte_cnt;
    logic        lat_read;
    logic [6:0]  lat_addr;
    logic [15:0] lat_reg;
    logic        lo_phase;
    logic        ack_smp;
    logic        start_d;
    logic        scl_r;
    logic        sda_r;
    logic        freeze;

`ifdef I2C_CLOCK_STRETCH_EN
    assign freeze = scl_r & ~SCL_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = SCL_in;
    assign freeze = 1'b0;
`endif

    assign SCL_out = scl_r;
    assign SCL_t   = scl_r;
    assign SDA_out = sda_r;
    assign SDA_t   = sda_r;

    // START has two quarters, RESTART/STOP three, every bit cell four
    always_comb begin
        case (state)
            START:         last_q = 2'd1;
            RESTART, STOP: last_q = 2'd2;
            default:       last_q = 2'd3;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            qtr       <= 2'd0;
            q_cnt     <= Q_LOAD;
            bit_cnt   <= 3'd0;
            tx_sh     <= 8'h00;
            rx_sh     <= 8'h00;
            byte_cnt  <= 10'd0;
            lat_read  <= 1'b0;
            lat_addr  <= 7'd0;
            lat_reg   <= 16'h0000;
            lo_phase  <= 1'b0;
            ack_smp   <= 1'b1;
            start_d   <= 1'b0;
            scl_r     <= 1'b1;
            sda_r     <= 1'b1;
            data_out  <= 16'h0000;
            ready     <= 1'b1;
            error_out <= 1'b0;
        end else begin
            start_d <= start;
            if (state == IDLE) begin
                if (start && !start_d) begin
                    lat_read  <= is_read;
                    lat_addr  <= slave_adress;
                    lat_reg   <= register_address;
                    byte_cnt  <= nb_of_bytes;
                    lo_phase  <= 1'b0;
                    ready     <= 1'b0;
                    error_out <= 1'b0;
                    state     <= START;
                    qtr       <= 2'd0;
                    q_cnt     <= Q_LOAD;
                end
            end else if (!freeze) begin
                if (q_cnt != 10'd0) begin
                    q_cnt <= q_cnt - 10'd1;
                end else begin
                    q_cnt <= Q_LOAD;
                    if (qtr != last_q) begin
                        qtr <= qtr + 2'd1;
                        case (state)
                            START:   sda_r <= 1'b0;
                            RESTART: if (qtr == 2'd0) scl_r <= 1'b1; else sda_r <= 1'b0;
                            STOP:    if (qtr == 2'd0) scl_r <= 1'b1; else sda_r <= 1'b1;
                            default: begin
                                if (qtr == 2'd1) scl_r <= 1'b1;
                                if (qtr == 2'd2) begin
                                    ack_smp <= SDA_in;
                                    if (state == RD_DATA) rx_sh <= {rx_sh[6:0], SDA_in};
                                end
                            end
                        endcase
                    end else begin
                        // end of cell: SCL drops and SDA takes the next cell's level
                        qtr   <= 2'd0;
                        scl_r <= 1'b0;
                        case (state)
                            START: begin
                                state <= ADDR; tx_sh <= {lat_addr, 1'b0};
                                sda_r <= lat_addr[6]; bit_cnt <= 3'd7;
                            end
                            ADDR, REG_HI, REG_LO, WR_DATA, ADDR_RD: begin
                                if (bit_cnt != 3'd0) begin
                                    bit_cnt <= bit_cnt - 3'd1;
                                    tx_sh   <= {tx_sh[6:0], 1'b0};
                                    sda_r   <= tx_sh[6];
                                end else begin
                                    sda_r <= 1'b1;
                                    case (state)
                                        ADDR:           state <= ADDR_ACK;
                                        REG_HI, REG_LO: state <= REG_ACK;
                                        WR_DATA:        state <= WR_ACK;
                                        default:        state <= ADDR_RD_ACK;
                                    endcase
                                end
                            end
                            ADDR_ACK, REG_ACK, WR_ACK, ADDR_RD_ACK: begin
                                if (ack_smp) begin
                                    error_out <= 1'b1; state <= STOP; sda_r <= 1'b0;
                                end else begin
                                    case (state)
                                        ADDR_ACK: begin
                                            state <= REG_HI; tx_sh <= lat_reg[15:8];
                                            sda_r <= lat_reg[15]; bit_cnt <= 3'd7;
                                        end
                                        REG_ACK: begin
                                            if (!lo_phase) begin
                                                lo_phase <= 1'b1; state <= REG_LO; tx_sh <= lat_reg[7:0];
                                                sda_r <= lat_reg[7]; bit_cnt <= 3'd7;
                                            end else if (byte_cnt == 10'd0) begin
                                                state <= STOP; sda_r <= 1'b0;
                                            end else if (lat_read) begin
                                                state <= RESTART; sda_r <= 1'b1;
                                            end else begin
                                                state <= WR_DATA; tx_sh <= data_in;
                                                sda_r <= data_in[7]; bit_cnt <= 3'd7;
                                            end
                                        end
                                        WR_ACK: begin
                                            byte_cnt <= byte_cnt - 10'd1;
                                            if (byte_cnt == 10'd1) begin
                                                state <= STOP; sda_r <= 1'b0;
                                            end else begin
                                                state <= WR_DATA; tx_sh <= data_in;
                                                sda_r <= data_in[7]; bit_cnt <= 3'd7;
                                            end
                                        end
                                        default: begin
                                            state <= RD_DATA; sda_r <= 1'b1; bit_cnt <= 3'd7;
                                        end
                                    endcase
                                end
                            end
                            RD_DATA: begin
                                if (bit_cnt != 3'd0) begin
                                    bit_cnt <= bit_cnt - 3'd1;
                                end else begin
                                    data_out <= {data_out[7:0], rx_sh};
                                    state    <= M_ACK;
                                    sda_r    <= (byte_cnt == 10'd1);
                                end
                            end
                            M_ACK: begin
                                byte_cnt <= byte_cnt - 10'd1;
                                if (byte_cnt == 10'd1) begin
                                    state <= STOP; sda_r <= 1'b0;
                                end else begin
                                    state <= RD_DATA; sda_r <= 1'b1; bit_cnt <= 3'd7;
                                end
                            end
                            RESTART: begin
                                state <= ADDR_RD; tx_sh <= {lat_addr, 1'b1};
                                sda_r <= lat_addr[6]; bit_cnt <= 3'd7;
                            end
                            STOP: begin
                                state <= IDLE; scl_r <= 1'b1; ready <= 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_entity.sv
// Directed bench for i2c_entity: a bus monitor plus a slave model decode the wire and answer ACK/data.
module tb_i2c_entity;
    localparam int QD = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_read = 1'b0;
    logic [6:0]  slave_adress = 7'd0;
    logic [15:0] register_address = 16'h0;
    logic [9:0]  nb_of_bytes = 10'd0;
    logic [7:0]  data_in = 8'h0;
    logic        SCL_in, SDA_in;
    logic [15:0] data_out;
    logic        ready, error_out, SCL_out, SDA_out, SCL_t, SDA_t;

    logic slv_sda = 1'b1;
    logic scl_hold = 1'b1;
    logic mon_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int log_q[$];
    int mack_q[$];
    int exp_q[$];
    int nack_at = -1;
    logic [7:0] rd_data [4];

    int bit_pos = 0, byte_in_frame = 0, nbytes = 0, rd_idx = 0;
    logic rd_mode = 1'b0, mack_nack = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1, scl_v, sda_v;
    logic [7:0] shreg = 8'h0, cur;

    assign SDA_in = SDA_out & slv_sda;
    assign SCL_in = SCL_out & scl_hold;

    i2c_entity #(.QUARTER_DIV(QD)) dut (
        .clock(clock), .reset(reset), .start(start), .is_read(is_read),
        .slave_adress(slave_adress), .register_address(register_address),
        .nb_of_bytes(nb_of_bytes), .data_in(data_in), .SCL_in(SCL_in), .SDA_in(SDA_in),
        .data_out(data_out), .ready(ready), .error_out(error_out),
        .SCL_out(SCL_out), .SDA_out(SDA_out), .SCL_t(SCL_t), .SDA_t(SDA_t)
    );

    always #5 clock = ~clock;

    // log codes: 0..255 byte, 256 START/Sr, 257 STOP
    always @(negedge clock) begin
        scl_v = SCL_out;
        sda_v = SDA_in;
        if (mon_clr) begin
            log_q.delete(); mack_q.delete();
            bit_pos = 0; byte_in_frame = 0; nbytes = 0; rd_idx = 0;
            rd_mode = 1'b0; mack_nack = 1'b0; slv_sda = 1'b1;
        end else if (prev_scl && scl_v && prev_sda && !sda_v) begin
            log_q.push_back(256); bit_pos = 0; byte_in_frame = 0; rd_mode = 1'b0;
        end else if (prev_scl && scl_v && !prev_sda && sda_v) begin
            log_q.push_back(257);
        end else if (!prev_scl && scl_v) begin
            if (bit_pos < 8) begin
                shreg = {shreg[6:0], sda_v};
                bit_pos++;
                if (bit_pos == 8) log_q.push_back(int'(shreg));
            end else begin
                if (rd_mode) begin
                    mack_q.push_back(int'(sda_v));
                    if (sda_v) mack_nack = 1'b1;
                    if (rd_idx < 3) rd_idx++;
                end
                if (byte_in_frame == 0 && shreg[0]) rd_mode = 1'b1;
                bit_pos = 0; byte_in_frame++; nbytes++;
            end
        end else if (prev_scl && !scl_v) begin
            if (bit_pos == 8) slv_sda = rd_mode ? 1'b1 : (nbytes == nack_at);
            else if (rd_mode && !mack_nack) begin
                cur = rd_data[rd_idx];
                slv_sda = cur[3'(7 - bit_pos)];
            end else slv_sda = 1'b1;
        end
        prev_scl = scl_v;
        prev_sda = sda_v;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < log_q.size()) chk(tag, log_q[i], exp_q[i]);
            else chk(tag, 32'hFFFF_FFFF, exp_q[i]);
        end
    endtask

    task automatic launch(input logic rd, input logic [6:0] a, input logic [15:0] r,
                          input logic [9:0] n, input logic [7:0] d);
        mon_clr = 1'b1; cyc(1); mon_clr = 1'b0;
        is_read = rd; slave_adress = a; register_address = r; nb_of_bytes = n; data_in = d;
        start = 1'b1;
        cyc(1);
        chk("ready_drop", 32'(ready), 1'b0);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 4000 && !ready; i++) cyc(1);
        chk({tag, "_ready"}, 32'(ready), 1'b1);
    endtask

    initial begin
        int bad;
        logic sv;
        rd_data[0] = 8'h5A; rd_data[1] = 8'hC3; rd_data[2] = 8'hFF; rd_data[3] = 8'hFF;
        cyc(3);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_error", 32'(error_out), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_scl", 32'(SCL_out), 1);
        chk("rst_sda", 32'(SDA_out), 1);
        chk("rst_scl_t", 32'(SCL_t), 1);
        chk("rst_sda_t", 32'(SDA_t), 1);
        reset = 1'b1;
        cyc(2);

        // register read, slave returns 5A then C3
        launch(1'b1, 7'h29, 16'hA6A6, 10'd2, 8'h00);
        start = 1'b0;
        wait_ready("rd");
        exp_q = '{256, 'h52, 'hA6, 'hA6, 256, 'h53, 'h5A, 'hC3, 257};
        chk_log("rd_bus");
        chk("rd_mack_len", 32'(mack_q.size()), 2);
        if (mack_q.size() == 2) begin
            chk("rd_mack0", mack_q[0], 0);
            chk("rd_mack1", mack_q[1], 1);
        end
        chk("rd_data", 32'(data_out), 'h5AC3);
        chk("rd_error", 32'(error_out), 0);

        // write one byte, start held high through completion
        launch(1'b0, 7'h29, 16'h0010, 10'd1, 8'h02);
        wait_ready("wr");
        exp_q = '{256, 'h52, 'h00, 'h10, 'h02, 257};
        chk_log("wr_bus");
        chk("wr_error", 32'(error_out), 0);
        cyc(20);
        chk("wr_no_retrig_ready", 32'(ready), 1);
        chk("wr_no_retrig_scl", 32'(SCL_out), 1);
        start = 1'b0;
        cyc(2);

        // slave NACKs the address
        nack_at = 0;
        launch(1'b1, 7'h29, 16'hA6A6, 10'd2, 8'h00);
        start = 1'b0;
        wait_ready("nack");
        exp_q = '{256, 'h52, 257};
        chk_log("nack_bus");
        chk("nack_error", 32'(error_out), 1);
        chk("nack_data", 32'(data_out), 'h5AC3);
        cyc(10);
        chk("nack_error_hold", 32'(error_out), 1);
        nack_at = -1;

        // zero-length write
        launch(1'b0, 7'h29, 16'h1234, 10'd0, 8'hEE);
        start = 1'b0;
        wait_ready("nb0");
        exp_q = '{256, 'h52, 'h12, 'h34, 257};
        chk_log("nb0_bus");
        chk("nb0_error", 32'(error_out), 0);

        // reset asserted during REG_LO
        launch(1'b0, 7'h29, 16'h0010, 10'd1, 8'h02);
        start = 1'b0;
        for (int i = 0; i < 2000 && log_q.size() < 3; i++) cyc(1);
        chk("rst_mid_reach", 32'(log_q.size()), 3);
        cyc(12);
        chk("rst_mid_pre_scl", 32'(SCL_out), 0);
        chk("rst_mid_pre_sda", 32'(SDA_out), 0);
        reset = 1'b0;
        #1;
        chk("rst_mid_scl_t", 32'(SCL_t), 1);
        chk("rst_mid_sda_t", 32'(SDA_t), 1);
        chk("rst_mid_ready", 32'(ready), 1);
        cyc(2);
        reset = 1'b1;
        cyc(2);
        launch(1'b0, 7'h29, 16'h0010, 10'd1, 8'h02);
        start = 1'b0;
        wait_ready("after_rst");
        exp_q = '{256, 'h52, 'h00, 'h10, 'h02, 257};
        chk_log("after_rst_bus");

`ifdef I2C_CLOCK_STRETCH_EN
        // hold SCL low 20 cycles during the first address bit's high phase
        launch(1'b0, 7'h29, 16'h0010, 10'd1, 8'h02);
        start = 1'b0;
        for (int i = 0; i < 200 && SCL_out; i++) cyc(1);
        for (int i = 0; i < 200 && !SCL_out; i++) cyc(1);
        chk("str_scl_high", 32'(SCL_out), 1);
        scl_hold = 1'b0;
        sv = SDA_out;
        bad = 0;
        repeat (20) begin
            cyc(1);
            if (SDA_out !== sv || SCL_out !== 1'b1) bad++;
        end
        chk("str_frozen", bad, 0);
        scl_hold = 1'b1;
        wait_ready("str");
        exp_q = '{256, 'h52, 'h00, 'h10, 'h02, 257};
        chk_log("str_bus");
        chk("str_error", 32'(error_out), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
